// File: rtl/turf_bus_to_axis.sv
// Purpose: bridges one TURF register-bus access into a 2-word AXI4-stream request and waits for a 1-word response.
// Latency: en_i sampled at edge 0 -> word0 cycle 1, word1 cycle 2, response taken cycle 3, ack_o cycle 4 (no stalls).
// Backpressure: request words hold tvalid/tdata through any m_axis_tready stall; responses are only accepted in RESP.
// Optional: TURF_BUS_AXIS_TIMEOUT_EN adds a response timeout, a sticky timeout_o flag and a stale-response drop.
module turf_bus_to_axis #(
  parameter int          ADR_BITS       = 28,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hBADC0FFE
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en_i,
  input  logic                wr_i,
  input  logic [ADR_BITS-1:0] adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  output logic                ack_o,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic                timeout_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ADR = 3'd1,
    REQ_DAT = 3'd2,
    RESP    = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word0_q, word0_d;
  logic [31:0] word1_q, word1_d;
  logic [31:0] dat_q,   dat_d;
  logic [27:0] adr_ext;

`ifdef TURF_BUS_AXIS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             tmo_q, tmo_d;
`else
  // Timeout configuration has no effect without the timeout feature.
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_DATA ^ 32'(TIMEOUT_CYCLES);
`endif

  // Next-state, request/response handshakes and ack generation.
  always_comb begin
    state_d       = state_q;
    word0_d       = word0_q;
    word1_d       = word1_q;
    dat_d         = dat_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 32'h0;
    s_axis_tready = 1'b0;
    ack_o         = 1'b0;
    adr_ext       = '0;
    adr_ext[ADR_BITS-1:0] = adr_i;
`ifdef TURF_BUS_AXIS_TIMEOUT_EN
    cnt_d  = cnt_q;
    drop_d = drop_q;
    tmo_d  = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (en_i) begin
          // Snapshot the bus so later changes cannot corrupt the frame.
          word0_d = {wr_i, 3'b000, adr_ext};
          word1_d = wr_i ? dat_i : 32'h0;
          state_d = REQ_ADR;
        end
      end
      REQ_ADR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = word0_q;
        if (m_axis_tready) state_d = REQ_DAT;
      end
      REQ_DAT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = word1_q;
        if (m_axis_tready) begin
          state_d = RESP;
`ifdef TURF_BUS_AXIS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RESP: begin
        s_axis_tready = 1'b1;
`ifdef TURF_BUS_AXIS_TIMEOUT_EN
        if (s_axis_tvalid && drop_q) begin
          // Late reply to a timed-out access: discard and keep waiting.
          drop_d = 1'b0;
          cnt_d  = '0;
        end else if (s_axis_tvalid) begin
          dat_d   = s_axis_tdata;
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          dat_d   = TIMEOUT_DATA;
          tmo_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        if (s_axis_tvalid) begin
          dat_d   = s_axis_tdata;
          state_d = ACK;
        end
`endif
      end
      ACK: begin
        ack_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef TURF_BUS_AXIS_TIMEOUT_EN
    // Outside RESP a pending stale reply is drained as soon as it shows up.
    if (drop_q && (state_q != RESP)) begin
      s_axis_tready = 1'b1;
      if (s_axis_tvalid) drop_d = 1'b0;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      word0_q <= 32'h0;
      word1_q <= 32'h0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
      dat_q   <= dat_d;
    end
  end

`ifdef TURF_BUS_AXIS_TIMEOUT_EN
  // Timeout counter, stale-reply drop flag and sticky timeout flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign dat_o = dat_q;

endmodule

// File: tb/tb_turf_bus_to_axis.sv
module tb_turf_bus_to_axis;
  localparam int TCYC = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        en_i, wr_i;
  logic [27:0] adr_i;
  logic [31:0] dat_i, dat_o;
  logic        ack_o;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic        timeout_o;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int s_cons  = 0;
  int cyc     = 0;
  logic [31:0] beats[$];

  turf_bus_to_axis #(.ADR_BITS(28), .TIMEOUT_CYCLES(TCYC), .TIMEOUT_DATA(32'hBADC0FFE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .en_i(en_i), .wr_i(wr_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .ack_o(ack_o),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .timeout_o(timeout_o)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Stream/bus observers sample mid-cycle, where handshakes are stable.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
    if (ack_o) ack_cnt++;
    if (s_axis_tvalid && s_axis_tready) s_cons++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full bus access; pre=1 means the caller already placed the response on s_axis.
  task automatic do_txn(input logic wr, input logic [27:0] adr, input logic [31:0] dat,
                        input logic [31:0] resp, input int bp0, input int bp1,
                        input int rdelay, input bit pre, input string tag);
    logic [31:0] w[2];
    int t0, acks0, hold, budget;
    w[0] = {wr, 3'b000, adr};
    w[1] = wr ? dat : 32'h0;
    beats.delete();
    acks0 = ack_cnt;
    en_i = 1'b1; wr_i = wr; adr_i = adr; dat_i = dat;
    m_axis_tready = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      budget = 0;
      while (!m_axis_tvalid && budget < 50) begin tick(); budget++; end
      check({tag, "_tvalid_seen"}, 32'(m_axis_tvalid), 32'd1);
      hold = (k == 0) ? bp0 : bp1;
      for (int i = 0; i < hold; i++) begin
        check({tag, "_stall_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_stall_tdata"}, m_axis_tdata, w[k]);
        tick();
      end
      check({tag, "_word"}, m_axis_tdata, w[k]);
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      if (k == 0) begin
        // Bus changes after launch must not reach the frame.
        adr_i = 28'($urandom); dat_i = $urandom; wr_i = ~wr;
      end
    end
    budget = 0;
    while (!s_axis_tready && budget < 50) begin tick(); budget++; end
    check({tag, "_resp_rdy"}, 32'(s_axis_tready), 32'd1);
    if (!pre) begin
      for (int i = 0; i < rdelay; i++) begin
        check({tag, "_no_early_ack"}, 32'(ack_o), 32'd0);
        tick();
      end
      s_axis_tdata = resp;
      s_axis_tvalid = 1'b1;
    end
    tick();
    s_axis_tvalid = 1'b0;
    check({tag, "_ack"}, 32'(ack_o), 32'd1);
    check({tag, "_dat_o"}, dat_o, resp);
    check({tag, "_latency"}, 32'(cyc - t0), 32'(4 + bp0 + bp1 + (pre ? 0 : rdelay)));
    en_i = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 32'(ack_o), 32'd0);
    check({tag, "_beats"}, 32'(beats.size()), 32'd2);
    if (beats.size() == 2) begin
      check({tag, "_beat0"}, beats[0], w[0]);
      check({tag, "_beat1"}, beats[1], w[1]);
    end
    check({tag, "_ack_count"}, 32'(ack_cnt - acks0), 32'd1);
  endtask

`ifdef TURF_BUS_AXIS_TIMEOUT_EN
  // Read that never gets an answer in time.
  task automatic do_timeout(input string tag);
    int r0, budget;
    en_i = 1'b1; wr_i = 1'b0; adr_i = 28'h0000020; m_axis_tready = 1'b1;
    budget = 0;
    while (!s_axis_tready && budget < 50) begin tick(); budget++; end
    r0 = cyc;
    budget = 0;
    while (!ack_o && budget < 100) begin tick(); budget++; end
    m_axis_tready = 1'b0;
    check({tag, "_ack"}, 32'(ack_o), 32'd1);
    check({tag, "_delay"}, 32'(cyc - r0), 32'(TCYC));
    check({tag, "_dat_o"}, dat_o, 32'hBADC0FFE);
    check({tag, "_flag"}, 32'(timeout_o), 32'd1);
    en_i = 1'b0;
    tick();
  endtask
`endif

  initial begin
    int c0, a0, budget;
    logic [31:0] r;
    aresetn = 1'b0;
    en_i = 1'b0; wr_i = 1'b0; adr_i = '0; dat_i = '0;
    m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    tick(); tick();
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    aresetn = 1'b1;
    tick();

    do_txn(1'b1, 28'h0000010, 32'h12345678, 32'h00000000, 0, 0, 0, 1'b0, "write");
    do_txn(1'b0, 28'h0000004, 32'hDEADBEEF, 32'hCAFEF00D, 0, 0, 0, 1'b0, "read");
    do_txn(1'b1, 28'hABCDEF1, 32'h0F0F0F0F, 32'h55AA55AA, 5, 3, 2, 1'b0, "bp");

    for (int n = 0; n < 8; n++) begin
      do_txn(1'($urandom), 28'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, "rand");
    end

    // Unsolicited response must sit on the link until a read launches.
    r = $urandom;
    s_axis_tdata = r; s_axis_tvalid = 1'b1;
    c0 = s_cons; a0 = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      check("unsol_tready", 32'(s_axis_tready), 32'd0);
      tick();
    end
    check("unsol_no_ack", 32'(ack_cnt - a0), 32'd0);
    do_txn(1'b0, 28'h0000008, 32'h0, r, 0, 0, 0, 1'b1, "unsol");
    check("unsol_consumed", 32'(s_cons - c0), 32'd1);

    // Reset while waiting for the response.
    en_i = 1'b1; wr_i = 1'b0; adr_i = 28'h0000044; m_axis_tready = 1'b1;
    budget = 0;
    while (!s_axis_tready && budget < 50) begin tick(); budget++; end
    check("rstmid_in_resp", 32'(s_axis_tready), 32'd1);
    a0 = ack_cnt;
    aresetn = 1'b0;
    #1;
    check("rstmid_ack", 32'(ack_o), 32'd0);
    check("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rstmid_tdata", m_axis_tdata, 32'h0);
    check("rstmid_tready", 32'(s_axis_tready), 32'd0);
    check("rstmid_dat_o", dat_o, 32'h0);
    en_i = 1'b0; m_axis_tready = 1'b0;
    tick();
    aresetn = 1'b1;
    tick(); tick();
    check("rstmid_no_ack", 32'(ack_cnt - a0), 32'd0);
    do_txn(1'b0, 28'h0000044, 32'h0, 32'h600DF00D, 0, 0, 1, 1'b0, "post_rst");

`ifdef TURF_BUS_AXIS_TIMEOUT_EN
    // Stale word arrives while idle.
    do_timeout("tmo1");
    c0 = s_cons;
    check("drop_idle_rdy", 32'(s_axis_tready), 32'd1);
    s_axis_tdata = 32'h11111111; s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    check("drop_cleared", 32'(s_axis_tready), 32'd0);
    check("drop_consumed", 32'(s_cons - c0), 32'd1);
    check("drop_dat_o", dat_o, 32'hBADC0FFE);
    do_txn(1'b0, 28'h0000030, 32'h0, 32'h22222222, 0, 0, 0, 1'b0, "after_drop");
    check("tmo_sticky", 32'(timeout_o), 32'd1);

    // Stale word arrives inside the next RESP.
    do_timeout("tmo2");
    en_i = 1'b1; wr_i = 1'b0; adr_i = 28'h0000034; m_axis_tready = 1'b1;
    budget = 0;
    while (!(m_axis_tvalid == 1'b0 && s_axis_tready && budget > 0) && budget < 50) begin
      tick(); budget++;
    end
    m_axis_tready = 1'b0;
    s_axis_tdata = 32'h11111111; s_axis_tvalid = 1'b1;
    tick();
    check("stale_resp_no_ack", 32'(ack_o), 32'd0);
    check("stale_resp_still_rdy", 32'(s_axis_tready), 32'd1);
    s_axis_tdata = 32'h33333333;
    tick();
    s_axis_tvalid = 1'b0;
    check("stale_resp_ack", 32'(ack_o), 32'd1);
    check("stale_resp_dat_o", dat_o, 32'h33333333);
    en_i = 1'b0;
    tick();
`else
    check("no_timeout_flag", 32'(timeout_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/turf_bus_to_axis.md
Name: turf_bus_to_axis

Overview:
- Bus-slave to AXI4-stream initiator bridge. It is the counterpart of turf_axis_rdwr.
- It accepts single en/wr/adr/dat transactions on the TURF generic register bus and serializes each one into a 2-word request stream.
- It waits for a 1-word response stream, then acks the bus.
- Placed between a local bus master (arbiter output or test logic) and a stream link (Xillybus/UDP FIFOs) so that register accesses can be forwarded to a remote turf_axis_rdwr.

Parameters:
- ADR_BITS, 28, bus address width; must be ≤28.
- TIMEOUT_CYCLES, 1024, response timeout in aclk cycles (used only with the optional feature).
- TIMEOUT_DATA, 32'hBADC0FFE, dat_o value returned on timeout.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- en_i  in  1  bus transaction request; held high until ack_o is seen.
- wr_i  in  1  1=write, 0=read; stable while en_i is high.
- adr_i  in  ADR_BITS  register address; stable while en_i is high.
- dat_i  in  32  write data; stable while en_i is high.
- dat_o  out  32  read data / response word; valid when ack_o=1.
- ack_o  out  1  one-cycle transaction-complete pulse.
- m_axis_tdata  out  32  request stream data.
- m_axis_tvalid  out  1  request stream valid.
- m_axis_tready  in  1  request stream ready.
- s_axis_tdata  in  32  response stream data.
- s_axis_tvalid  in  1  response stream valid.
- s_axis_tready  out  1  response stream ready.
- timeout_o  out  1  sticky timeout flag (tied 0 without the optional feature).

Behaviour:
- Request format:
  - word0 = {wr_i, 3'b000, zero-extended adr_i to 28 bits}.
  - word1 = dat_i for writes, 32'h0 for reads.
  - Both words are latched from the bus on launch; later bus changes are ignored.
- Response format: one 32-bit word, for both reads and writes. The word is registered into dat_o.
- Reset (aresetn=0, async): state=IDLE, ack_o=0, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, dat_o=0, timeout_o=0, counters and drop flag cleared.
- Reset mid-transaction: the transaction is abandoned with no ack. Any partial stream frame is the link owner's problem; the link FIFOs are reset together with this block.
- FSM states: IDLE, REQ_ADR, REQ_DAT, RESP, ACK.
  - IDLE: en_i=1 sampled → latch words → REQ_ADR.
  - REQ_ADR: m_axis_tvalid=1, tdata=word0. On tvalid&&tready → REQ_DAT.
  - REQ_DAT: m_axis_tvalid=1, tdata=word1. On handshake → RESP.
  - RESP: s_axis_tready=1. On s_axis_tvalid → dat_o<=s_axis_tdata → ACK.
  - ACK: ack_o=1 for exactly one cycle → IDLE.
- AXI rules: tvalid never drops, and tdata never changes, until the handshake completes. Backpressure of any length is tolerated.
- Latency with tready=1 and the response present: en_i sampled at edge 0 → word0 in cycle 1, word1 in cycle 2, response accepted in cycle 3, ack_o in cycle 4.
- s_axis_tready=0 outside RESP. Unsolicited response words are back-pressured, never consumed (exception: drop rule below).
- Back-to-back: the master drops en_i in the cycle after ack_o. If en_i is still high in IDLE, a new transaction launches. This is intended behaviour.
- dat_o holds its last value until the next response or timeout.

Optional Feature:
- Macro: TURF_BUS_AXIS_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to RESP and increments each cycle in RESP.
  - If it reaches TIMEOUT_CYCLES-1 with no response: dat_o<=TIMEOUT_DATA, timeout_o<=1 (sticky until reset), go to ACK, and set drop_pending.
  - While drop_pending=1, s_axis_tready=1 in every state except RESP. The next response word is consumed and discarded, then drop_pending clears.
  - If the stale word arrives during a new RESP, it is discarded first. The FSM stays in RESP, the timeout counter restarts, and the following word is the real response.
- Without the macro: no counter, no drop logic. RESP waits forever; timeout_o=0.

Test Plan:
- Write: en_i=1, wr_i=1, adr_i=28'h0000010, dat_i=32'h12345678, tready=1, response 32'h0 → m_axis words 32'h80000010 then 32'h12345678; ack_o in cycle 4; dat_o=0.
- Read: wr_i=0, adr_i=28'h0000004, response 32'hCAFEF00D → words 32'h00000004 and 32'h00000000; ack_o one cycle; dat_o=32'hCAFEF00D.
- Backpressure: m_axis_tready held low 5 cycles at word0 and 3 cycles at word1 → tvalid and tdata stable throughout; exactly 2 beats transferred; one ack_o.
- Unsolicited response: s_axis_tvalid=1 in IDLE → s_axis_tready stays 0, no ack_o. A later read launch consumes that word as its response.
- Reset mid-RESP: aresetn low for 1 cycle → all outputs 0 asynchronously, no ack_o; a following read completes normally.
- (TIMEOUT_EN, TIMEOUT_CYCLES=16) Read with no response → ack_o 16 cycles after entering RESP; dat_o=32'hBADC0FFE; timeout_o=1. A late word 32'h11111111 is dropped; the next read returns its own response 32'h22222222.
